// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared FSM states, halt word and opcode fields for the instruction memory
package imem_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } imem_state_t;

  localparam logic [31:0] HALT_WORD = 32'hE400_0000;

  localparam int         OPC_MSB  = 31;
  localparam int         OPC_LSB  = 26;
  localparam logic [5:0] OPC_HALT = 6'b111001;

  function automatic logic is_halt(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - load FSM, write pointer and overflow flag; bounds behaviour set by IMEM_BOUNDS_CHECK_EN
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              cpu_hold,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  imem_state_t     state, state_nxt;
  logic [ADDR_W:0] ptr, ptr_nxt;
  logic            done_nxt;
  logic            accept;

  assign load_ready = (state == ST_LOAD);
  assign cpu_hold   = (state == ST_LOAD);
  // A restart pulse takes priority over a word presented in the same cycle
  assign accept     = load_valid & load_ready & ~load_start;
  assign mem_wdata  = load_data;

`ifdef IMEM_BOUNDS_CHECK_EN
  logic in_range;
  logic err_q, err_nxt;

  assign in_range  = (ptr < DEPTH_W);
  assign mem_waddr = IDX_W'(ptr);
  assign load_err  = err_q;
`else
  assign mem_waddr = IDX_W'(ptr % DEPTH_W);
  assign load_err  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    mem_we    = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
    err_nxt   = err_q;
`endif
    if (load_start) begin
      state_nxt = ST_LOAD;
      ptr_nxt   = {1'b0, load_base};
`ifdef IMEM_BOUNDS_CHECK_EN
      err_nxt   = 1'b0;
`endif
    end else if (accept) begin
`ifdef IMEM_BOUNDS_CHECK_EN
      if (in_range) begin
        mem_we  = 1'b1;
        ptr_nxt = ptr + 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
`else
      mem_we  = 1'b1;
      ptr_nxt = ptr + 1'b1;
`endif
      if (load_last) begin
        state_nxt = ST_RUN;
        done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      ptr       <= '0;
      load_done <= 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      load_done <= done_nxt;
`ifdef IMEM_BOUNDS_CHECK_EN
      err_q     <= err_nxt;
`endif
    end
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - loadable instruction memory with registered fetch port; IMEM_BOUNDS_CHECK_EN selects fault vs wrap
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 11,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(HALT_WORD)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst,
  output logic              fetch_valid,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              cpu_hold
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  // Contents start as halt words and are deliberately untouched by reset_n
  logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL_WORD};

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              fetch_acc;
  logic              pc_oob;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  imem_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_loader (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_err   (load_err),
    .cpu_hold   (cpu_hold),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata)
  );

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  assign pc_oob  = ({1'b0, pc} >= DEPTH_W);
  assign rd_idx  = IDX_W'(pc);
  assign rd_word = pc_oob ? FILL_WORD : mem[rd_idx];
`else
  assign pc_oob  = 1'b0;
  assign rd_idx  = IDX_W'({1'b0, pc} % DEPTH_W);
  assign rd_word = mem[rd_idx];
`endif

  // Loading and fetching are exclusive, so a read never races a write
  assign fetch_acc = fetch_req & ~cpu_hold & ~load_start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inst        <= FILL_WORD;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        inst        <= rd_word;
        fetch_fault <= pc_oob;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - scoreboard bench for instr_fetch_mem
module tb_instr_fetch_mem;

  localparam int          DEPTH = 32;
  localparam logic [31:0] FILL  = 32'hE400_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic [10:0] pc;
  logic [31:0] inst;
  logic        fetch_valid;
  logic        fetch_fault;
  logic        load_start;
  logic [10:0] load_base;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        load_err;
  logic        cpu_hold;

  typedef struct packed {
    logic [31:0] word;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  int          mptr;
  logic        merr;
  int          n_checks = 0;
  int          n_pass   = 0;

  instr_fetch_mem dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .inst        (inst),
    .fetch_valid (fetch_valid),
    .fetch_fault (fetch_fault),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .load_err    (load_err),
    .cpu_hold    (cpu_hold)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t expect_fetch(input int a);
    exp_t e;
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a >= DEPTH) begin
      e.word  = FILL;
      e.fault = 1'b1;
    end else begin
      e.word  = model[a];
      e.fault = 1'b0;
    end
`else
    e.word  = model[a % DEPTH];
    e.fault = 1'b0;
`endif
    return e;
  endfunction

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = $urandom;
  endtask

  task automatic tick();
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input int a);
    @(negedge clock);
    idle_inputs();
    fetch_req = 1'b1;
    pc        = 11'(a);
    exp_q.push_back(expect_fetch(a));
  endtask

  task automatic start_load(input int base, input bit with_fetch);
    @(negedge clock);
    idle_inputs();
    load_start = 1'b1;
    load_base  = 11'(base);
    if (with_fetch) begin
      fetch_req = 1'b1;
      pc        = 11'd3;
    end
    mptr = base;
    merr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    @(negedge clock);
    idle_inputs();
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
`ifdef IMEM_BOUNDS_CHECK_EN
    if (mptr < DEPTH) begin
      model[mptr] = d;
      mptr++;
    end else begin
      merr = 1'b1;
    end
`else
    model[mptr % DEPTH] = d;
    mptr++;
`endif
  endtask

  // Every cycle: a queued expectation must appear, otherwise fetch_valid stays low
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("fetch_valid", fetch_valid, 1);
        check("inst", inst, e.word);
        check("fetch_fault", fetch_fault, e.fault);
      end else begin
        check("fetch_idle", fetch_valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = FILL;
    idle_inputs();
    pc        = '0;
    load_base = '0;
    mptr      = 0;
    merr      = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_inst", inst, FILL);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_fault", fetch_fault, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) fetch(a);
    tick();

    start_load(0, 0);
    settle();
    check("load_cpu_hold", cpu_hold, 1);
    check("load_ready", load_ready, 1);
    check("load_done_early", load_done, 0);
    for (int i = 0; i < 12; i++)
      send_word((i == 11) ? 32'hE420_300A : 32'h2000_0000 + 32'(i), i == 11);
    settle();
    check("load_done_pulse", load_done, 1);
    check("done_cpu_hold", cpu_hold, 0);
    check("done_load_ready", load_ready, 0);
    check("done_load_err", load_err, merr);
    tick();
    settle();
    check("load_done_once", load_done, 0);
    fetch(11);
    for (int a = 0; a < 12; a++) fetch(a);
    tick();

    start_load(4, 0);
    send_word(32'hAAAA_0004, 0);
    tick();
    send_word(32'hBBBB_0005, 1);
    settle();
    check("gap_load_done", load_done, 1);
    fetch(4);
    fetch(5);
    fetch(6);
    tick();

`ifdef IMEM_BOUNDS_CHECK_EN
    start_load(30, 0);
    for (int i = 0; i < 4; i++) send_word(32'hC000_0030 + 32'(i), i == 3);
    settle();
    check("ovf_load_err", load_err, merr);
    check("ovf_load_done", load_done, 1);
    fetch(30);
    fetch(31);
    fetch(40);
    fetch(0);
    start_load(40, 0);
    settle();
    check("err_cleared", load_err, 0);
    send_word(32'hDEAD_0040, 1);
    settle();
    check("base_oob_err", load_err, merr);
    fetch(40);
    fetch(8);
    tick();
`else
    start_load(30, 0);
    for (int i = 0; i < 4; i++) send_word(32'hC000_0030 + 32'(i), i == 3);
    settle();
    check("wrap_load_err", load_err, 0);
    fetch(30);
    fetch(31);
    fetch(0);
    fetch(1);
    fetch(33);
    fetch(2047);
    tick();
`endif

    start_load(8, 1);
    send_word(32'h1111_0008, 0);
    start_load(20, 0);
    settle();
    check("restart_hold", cpu_hold, 1);
    send_word(32'h2222_0020, 1);
    settle();
    check("restart_done", load_done, 1);
    fetch(8);
    fetch(9);
    fetch(20);
    fetch(21);
    tick();

    start_load(0, 0);
    for (int i = 0; i < 3; i++) send_word(32'hE000_0000 + 32'(i), 0);
    settle();
    #2;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    #1;
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_ready", load_ready, 0);
    check("mid_rst_inst", inst, FILL);
    mptr = 0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) fetch(a);
    tick();
    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
